i2c_master: RTL and testbench

- Single-master I2C controller; the initiator that drives the bus toward the team's i2c_slave.
- Takes byte-level commands from a local controller and generates START, repeated START, 8-bit write/read with ACK slot, and STOP.
- Drives SCL/SDA open-drain through output-enable pins (oe=1 pulls line low, oe=0 releases).
- Supports slave clock stretching; no multi-master arbitration.

---
 rtl/i2c_master.sv | 169 ++++++++++++++++
 tb/tb_i2c_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C controller: START/repeated START, byte write/read with ACK slot, STOP; open-drain via oe pins.
// Latency: START/STOP 4*CLK_DIV, byte+ACK 36*CLK_DIV cycles; commands taken only while busy=0; SCL stretching stalls phases.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       cmd_vld,
    input  logic       cmd_start,
    input  logic       cmd_xfer,
    input  logic       cmd_rd,
    input  logic       cmd_ack,
    input  logic       cmd_stop,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_vld,
    output logic       rx_nack,
    input  logic       scl_in,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_oe
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_VLD  = CW'(CLK_DIV - 2);

    state_t        state;
    logic [1:0]    phase;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sr;
    logic          ack_bit;
    logic          owned;
    logic          c_rd, c_ack, c_xfer, c_stop;

    logic   stall, tick, adv, drv_bit;
    state_t tgt_state;
    logic [1:0] tgt_phase;

    function automatic state_t step_after(input state_t s, input logic [2:0] bi,
                                          input logic xfer, input logic stop);
        case (s)
            S_START: step_after = xfer ? S_BIT : (stop ? S_STOP : S_IDLE);
            S_BIT:   step_after = (bi == 3'd7) ? S_ACK : S_BIT;
            S_ACK:   step_after = stop ? S_STOP : S_IDLE;
            default: step_after = S_IDLE;
        endcase
    endfunction

    function automatic logic scl_next(input state_t s, input logic [1:0] p, input logic cur);
        scl_next = cur;
        if (p == 2'd1)
            scl_next = 1'b0;
        else if (p == 2'd0 && s != S_START)
            scl_next = 1'b1;
        else if (p == 2'd3 && s == S_START)
            scl_next = 1'b1;
    endfunction

    function automatic logic sda_next(input state_t s, input logic [1:0] p,
                                      input logic cur, input logic drv);
        sda_next = cur;
        case (s)
            S_START: begin
                if (p == 2'd0)      sda_next = 1'b0;
                else if (p == 2'd2) sda_next = 1'b1;
            end
            S_BIT, S_ACK: begin
                if (p == 2'd0) sda_next = drv;
            end
            S_STOP: begin
                if (p == 2'd0)      sda_next = 1'b1;
                else if (p == 2'd2) sda_next = 1'b0;
            end
            default: ;
        endcase
    endfunction

    // Phase counter only runs while SCL is actually high whenever we have released it.
    assign stall     = (state != S_IDLE) && !scl_oe && !scl_in;
    assign tick      = (cnt == CNT_LAST);
    assign adv       = (state != S_IDLE) && !stall && tick;
    assign tgt_state = (phase == 2'd3) ? step_after(state, bit_idx, c_xfer, c_stop) : state;
    assign tgt_phase = phase + 2'd1;
    assign drv_bit   = (tgt_state == S_BIT) ? (c_rd ? 1'b0 : ~sr[7]) : (c_rd ? ~c_ack : 1'b0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= S_IDLE;
            phase    <= 2'd0;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            sr       <= 8'h00;
            ack_bit  <= 1'b0;
            owned    <= 1'b0;
            c_rd     <= 1'b0;
            c_ack    <= 1'b0;
            c_xfer   <= 1'b0;
            c_stop   <= 1'b0;
            busy     <= 1'b0;
            data_out <= 8'h00;
            data_vld <= 1'b0;
            rx_nack  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            data_vld <= 1'b0;
            if (state == S_IDLE) begin
                if (cmd_vld && (cmd_start || cmd_xfer || cmd_stop)) begin
                    c_rd    <= cmd_rd;
                    c_ack   <= cmd_ack;
                    c_xfer  <= cmd_xfer;
                    c_stop  <= cmd_stop;
                    sr      <= data_in;
                    bit_idx <= 3'd0;
                    cnt     <= '0;
                    phase   <= 2'd0;
                    busy    <= 1'b1;
                    if (cmd_start || !owned) begin
                        state  <= S_START;
                        sda_oe <= 1'b0;
                    end else if (cmd_xfer) begin
                        state  <= S_BIT;
                        scl_oe <= 1'b1;
                        sda_oe <= cmd_rd ? 1'b0 : ~data_in[7];
                    end else begin
                        state  <= S_STOP;
                        scl_oe <= 1'b1;
                        sda_oe <= 1'b1;
                    end
                end
            end else begin
                if (!stall)
                    cnt <= tick ? '0 : cnt + 1'b1;
                if (phase == 2'd2 && cnt == '0 && !stall) begin
                    if (state == S_BIT) sr      <= {sr[6:0], sda_in};
                    if (state == S_ACK) ack_bit <= sda_in;
                end
                if (state == S_ACK && phase == 2'd3 && cnt == CNT_VLD && !stall) begin
                    data_vld <= 1'b1;
                    if (c_rd) data_out <= sr;
                    else      rx_nack  <= ack_bit;
                end
                if (adv) begin
                    phase <= tgt_phase;
                    state <= tgt_state;
                    if (state == S_BIT && phase == 2'd3)
                        bit_idx <= bit_idx + 3'd1;
                    if (state == S_START && phase == 2'd3)
                        owned <= 1'b1;
                    if (tgt_state == S_IDLE) begin
                        busy <= 1'b0;
                        // An owned bus parks with SCL low; after STOP both lines are already free.
                        if (state == S_STOP) owned  <= 1'b0;
                        else                 scl_oe <= 1'b1;
                    end else begin
                        scl_oe <= scl_next(tgt_state, tgt_phase, scl_oe);
                        sda_oe <= sda_next(tgt_state, tgt_phase, sda_oe, drv_bit);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bus-level slave model, line monitor and hand-computed expectations.
module tb_i2c_master;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       cmd_vld = 1'b0, cmd_start = 1'b0, cmd_xfer = 1'b0, cmd_rd = 1'b0;
    logic       cmd_ack = 1'b0, cmd_stop = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy, data_vld, rx_nack, scl_oe, sda_oe;
    logic [7:0] data_out;
    wire        scl_in, sda_in;

    logic       slave_sda_low = 1'b0;
    logic       slave_scl_hold = 1'b0;
    int         slave_mode = 0;       // 0 absent, 1 ACK writes, 2 return slave_byte
    logic [7:0] slave_byte = 8'h00;
    logic       stretch_arm = 1'b0;

    int         start_cnt = 0, stop_cnt = 0, vld_cnt = 0, bitcnt = 20;
    logic [7:0] mon_sh = 8'h00, mon_byte = 8'h00, vld_dout = 8'h00;
    logic       mon_ack = 1'b0, vld_nack = 1'b0;
    logic       pscl = 1'b1, psda = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    assign scl_in = ~scl_oe & ~slave_scl_hold;
    assign sda_in = ~sda_oe & ~slave_sda_low;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(4)) dut (
        .clk(clk), .rstb(rstb), .cmd_vld(cmd_vld), .cmd_start(cmd_start), .cmd_xfer(cmd_xfer),
        .cmd_rd(cmd_rd), .cmd_ack(cmd_ack), .cmd_stop(cmd_stop), .data_in(data_in),
        .busy(busy), .data_out(data_out), .data_vld(data_vld), .rx_nack(rx_nack),
        .scl_in(scl_in), .scl_oe(scl_oe), .sda_in(sda_in), .sda_oe(sda_oe)
    );

    // Bus monitor plus slave: data changes only right after SCL falls.
    initial begin
        forever begin
            @(negedge clk);
            if (pscl && scl_in && psda && !sda_in) begin
                start_cnt++;
                bitcnt = 0;
            end else if (pscl && scl_in && !psda && sda_in) begin
                stop_cnt++;
            end
            if (!pscl && scl_in) begin
                if (bitcnt < 8) mon_sh = {mon_sh[6:0], sda_in};
                else if (bitcnt == 8) begin
                    mon_byte = mon_sh;
                    mon_ack  = sda_in;
                end
                if (bitcnt < 20) bitcnt++;
            end
            if (pscl && !scl_in) begin
                if (slave_mode == 2 && bitcnt < 8) slave_sda_low = ~slave_byte[3'(7 - bitcnt)];
                else if (slave_mode == 1 && bitcnt == 8) slave_sda_low = 1'b1;
                else slave_sda_low = 1'b0;
            end
            if (data_vld) begin
                vld_cnt++;
                vld_dout = data_out;
                vld_nack = rx_nack;
            end
            pscl = scl_in;
            psda = sda_in;
        end
    end

    // Holds SCL low for 50 cycles from the moment the master releases it in bit 3.
    initial begin
        logic prev;
        int   rises;
        wait (stretch_arm);
        prev  = scl_oe;
        rises = 0;
        for (int i = 0; i < 2000 && rises < 4; i++) begin
            @(negedge clk);
            if (scl_oe && !prev) rises++;
            prev = scl_oe;
        end
        slave_scl_hold = 1'b1;
        for (int i = 0; i < 200 && scl_oe; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        slave_scl_hold = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic s, input logic x, input logic r, input logic a,
                         input logic p, input logic [7:0] d);
        @(negedge clk);
        cmd_start = s; cmd_xfer = x; cmd_rd = r; cmd_ack = a; cmd_stop = p;
        data_in = d;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic do_cmd(input logic s, input logic x, input logic r, input logic a,
                          input logic p, input logic [7:0] d, output int cyc);
        issue(s, x, r, a, p, d);
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, s0, p0, v0, k;

        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_data_vld", data_vld, 0);
        check("rst_rx_nack", rx_nack, 0);
        check("rst_data_out", data_out, 8'h00);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        do_cmd(0, 0, 0, 0, 0, 8'hFF, cyc);
        check("empty_cmd_busy", cyc, 0);

        // write 0xA0, start+stop, slave ACKs
        slave_mode = 1;
        s0 = start_cnt; p0 = stop_cnt; v0 = vld_cnt;
        do_cmd(1, 1, 0, 0, 1, 8'hA0, cyc);
        check("wr_busy_cycles", cyc, 176);
        check("wr_bus_byte", mon_byte, 8'hA0);
        check("wr_bus_ack", mon_ack, 0);
        check("wr_vld_count", vld_cnt - v0, 1);
        check("wr_rx_nack", vld_nack, 0);
        check("wr_starts", start_cnt - s0, 1);
        check("wr_stops", stop_cnt - p0, 1);
        check("wr_scl_free", scl_oe, 0);
        check("wr_sda_free", sda_oe, 0);

        // read 0xA5 with NACK and stop
        slave_mode = 2; slave_byte = 8'hA5;
        p0 = stop_cnt;
        do_cmd(1, 1, 1, 1, 1, 8'h00, cyc);
        check("rd_busy_cycles", cyc, 176);
        check("rd_data_out", vld_dout, 8'hA5);
        check("rd_bus_byte", mon_byte, 8'hA5);
        check("rd_master_nack", mon_ack, 1);
        check("rd_stops", stop_cnt - p0, 1);

        // write 0x3C to absent device, then stop-only
        slave_mode = 0;
        p0 = stop_cnt;
        do_cmd(1, 1, 0, 0, 0, 8'h3C, cyc);
        check("nodev_busy_cycles", cyc, 160);
        check("nodev_rx_nack", vld_nack, 1);
        check("nodev_bus_byte", mon_byte, 8'h3C);
        check("nodev_no_stop", stop_cnt - p0, 0);
        check("nodev_scl_held", scl_oe, 1);
        v0 = vld_cnt;
        do_cmd(0, 0, 0, 0, 1, 8'hFF, cyc);
        check("stop_only_cycles", cyc, 16);
        check("stop_only_no_vld", vld_cnt - v0, 0);
        check("stop_only_stops", stop_cnt - p0, 1);

        // write without stop, then repeated START + read
        slave_mode = 1;
        do_cmd(1, 1, 0, 0, 0, 8'h55, cyc);
        check("own_wr_cycles", cyc, 160);
        repeat (5) @(negedge clk);
        check("own_scl_low", scl_in, 0);
        slave_mode = 2; slave_byte = 8'h5A;
        s0 = start_cnt; p0 = stop_cnt;
        do_cmd(1, 1, 1, 0, 0, 8'h00, cyc);
        check("rs_rd_cycles", cyc, 160);
        check("rs_start_seen", start_cnt - s0, 1);
        check("rs_data_out", vld_dout, 8'h5A);
        check("rs_master_ack", mon_ack, 0);
        check("rs_no_stop", stop_cnt - p0, 0);
        do_cmd(0, 0, 0, 0, 1, 8'h00, cyc);
        check("rs_stop_cycles", cyc, 16);

        // clock stretching in bit 3
        slave_mode = 1;
        stretch_arm = 1'b1;
        do_cmd(1, 1, 0, 0, 1, 8'h96, cyc);
        stretch_arm = 1'b0;
        check("str_busy_cycles", cyc, 226);
        check("str_bus_byte", mon_byte, 8'h96);
        check("str_rx_nack", vld_nack, 0);

        // asynchronous reset during bit 5
        issue(1, 1, 0, 0, 1, 8'hF0);
        k = 0;
        while (bitcnt != 5 && k < 2000) begin
            k++;
            @(negedge clk);
        end
        check("mid_reached_bit5", bitcnt, 5);
        #2 rstb = 1'b0;
        #1;
        check("mid_rst_scl_oe", scl_oe, 0);
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        p0 = stop_cnt;
        do_cmd(1, 1, 0, 0, 1, 8'hC3, cyc);
        check("post_rst_cycles", cyc, 176);
        check("post_rst_byte", mon_byte, 8'hC3);
        check("post_rst_rx_nack", vld_nack, 0);
        check("post_rst_stop", stop_cnt - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
